// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

   localparam int         PEND_W   = 4;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // One-hot register mask; x0 maps to an empty mask so it can never be marked busy.
   function automatic logic [31:0] reg_onehot(input logic [4:0] r);
      logic [31:0] m;
      m = '0;
      if (r != REG_ZERO) m[r] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hazard_forward.sv
// Execute-stage operand forwarding select for one source operand (M beats W).
module hazard_forward
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rd_m_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_w_i,
   output fwd_sel_t   sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (reg_write_m_i && (rd_m_i != REG_ZERO) && (rd_m_i == rs_e_i)) begin
         sel_o = FWD_M;
      end else if (reg_write_w_i && (rd_w_i != REG_ZERO) && (rd_w_i == rs_e_i)) begin
         sel_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard controller: long-latency write scoreboard, stall/flush control, forwarding.
// Optional performance counters StallCycles/FlushCycles are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int MAX_PENDING = 4,
   parameter int CNT_W       = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic [4:0]        RdD,
   input  logic              RegWriteD,
   input  logic              LongLatD,
   input  logic [4:0]        Rs1E,
   input  logic [4:0]        Rs2E,
   input  logic [4:0]        RdM,
   input  logic              RegWriteM,
   input  logic [4:0]        RdW,
   input  logic              RegWriteW,
   input  logic              LongLatW,
   input  logic              PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic [31:0]       Busy,
   output logic [PEND_W-1:0] PendingCnt
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]  StallCycles,
   output logic [CNT_W-1:0]  FlushCycles
`endif
);

   logic [31:0]       busy_q, busy_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              cap_full, haz, issue, retire, retire_eff;
   fwd_sel_t          fwd_a, fwd_b;

   // Hazard is evaluated on registered state only, so a same-cycle retire still stalls.
   assign cap_full   = (pend_q == PEND_W'(MAX_PENDING));
   assign haz        = busy_q[Rs1D] | busy_q[Rs2D] | (RegWriteD & busy_q[RdD])
                     | (LongLatD & cap_full);
   assign issue      = rst_n & ~haz & ~PCSrcE & RegWriteD & LongLatD & (RdD != REG_ZERO);
   assign retire     = RegWriteW & LongLatW & (RdW != REG_ZERO);
   assign retire_eff = retire & (pend_q != '0);

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (!rst_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (haz) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   // Clear before set so an issue to the retiring register leaves it busy.
   always_comb begin
      busy_d = busy_q;
      pend_d = pend_q;
      if (retire_eff) busy_d = busy_d & ~reg_onehot(RdW);
      if (issue)      busy_d = busy_d | reg_onehot(RdD);
      case ({issue, retire_eff})
         2'b10:   pend_d = pend_q + PEND_W'(1);
         2'b01:   pend_d = pend_q - PEND_W'(1);
         default: pend_d = pend_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

   assign Busy       = busy_q;
   assign PendingCnt = pend_q;

   hazard_forward u_fwd_a (
      .rs_e_i        (Rs1E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .sel_o         (fwd_a)
   );

   hazard_forward u_fwd_b (
      .rs_e_i        (Rs2E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .sel_o         (fwd_b)
   );

   assign ForwardAE = rst_n ? fwd_a : FWD_RF;
   assign ForwardBE = rst_n ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallD) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (PCSrcE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign StallCycles = stall_cnt_q;
   assign FlushCycles = flush_cnt_q;
`else
   logic [CNT_W-1:0] perf_unused;
   assign perf_unused = '0;
`endif

   // A retire with nothing outstanding means the pipeline lost track of an op.
   assert property (@(posedge clk) disable iff (!rst_n) !(retire && (pend_q == '0)))
      else $error("retire with no outstanding long-latency op");
   assert property (@(posedge clk) disable iff (!rst_n)
                    (pend_q <= PEND_W'(MAX_PENDING)) && !busy_q[0])
      else $error("scoreboard count or x0 busy bit out of range");

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against an in-flight-list reference model.
module tb_hazard_scoreboard;

   localparam int MAX_PENDING = 4;
   localparam int CNT_W       = 32;
   localparam int EXP_W       = 44;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdM, RdW;
   logic        RegWriteD, LongLatD, RegWriteM, RegWriteW, LongLatW, PCSrcE;
   logic        StallF, StallD, FlushD, FlushE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] Busy;
   logic [3:0]  PendingCnt;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] StallCycles, FlushCycles;
   logic [CNT_W-1:0] stall_m, flush_m;
   logic [2*CNT_W-1:0] perf_q[$];
`endif

   always #5 clk = ~clk;

   hazard_scoreboard #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RdD        (RdD),
      .RegWriteD  (RegWriteD),
      .LongLatD   (LongLatD),
      .Rs1E       (Rs1E),
      .Rs2E       (Rs2E),
      .RdM        (RdM),
      .RegWriteM  (RegWriteM),
      .RdW        (RdW),
      .RegWriteW  (RegWriteW),
      .LongLatW   (LongLatW),
      .PCSrcE     (PCSrcE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .Busy       (Busy),
      .PendingCnt (PendingCnt)
`ifdef HAZARD_PERF_EN
      ,
      .StallCycles(StallCycles),
      .FlushCycles(FlushCycles)
`endif
   );

   // Reference state: the list of registers with a long-latency write in flight.
   int               inflight[$];
   logic [EXP_W-1:0] exp_q[$];
   int               checks = 0;
   int               errors = 0;

   function automatic bit is_busy(input logic [4:0] r);
      foreach (inflight[i]) if (inflight[i] == int'(r)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] busy_vec();
      logic [31:0] v;
      v = '0;
      foreach (inflight[i]) v[inflight[i]] = 1'b1;
      return v;
   endfunction

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic remove_reg(input logic [4:0] r);
      foreach (inflight[i]) begin
         if (inflight[i] == int'(r)) begin
            inflight.delete(i);
            return;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; LongLatD = 0;
      Rs1E = 0; Rs2E = 0; RdM = 0; RegWriteM = 0;
      RdW = 0; RegWriteW = 0; LongLatW = 0; PCSrcE = 0;
   endtask

   // Driver: inputs are already applied; predict this cycle, advance the model, step a clock.
   task automatic cycle();
      bit         haz, issue, retire;
      logic [3:0] ctl;
      logic [1:0] fa, fb;
      haz = is_busy(Rs1D) || is_busy(Rs2D) || (RegWriteD && is_busy(RdD))
         || (LongLatD && inflight.size() == MAX_PENDING);
      if (!rst_n)      ctl = 4'b0011;
      else if (PCSrcE) ctl = 4'b0011;
      else if (haz)    ctl = 4'b1101;
      else             ctl = 4'b0000;
      fa = rst_n ? fwd_ref(Rs1E) : 2'b00;
      fb = rst_n ? fwd_ref(Rs2E) : 2'b00;
      exp_q.push_back({ctl, fa, fb, busy_vec(), 4'(inflight.size())});
`ifdef HAZARD_PERF_EN
      perf_q.push_back({stall_m, flush_m});
      if (!rst_n) begin
         stall_m = '0;
         flush_m = '0;
      end else begin
         stall_m = stall_m + CNT_W'(ctl[2]);
         flush_m = flush_m + CNT_W'(PCSrcE);
      end
`endif
      if (!rst_n) begin
         inflight.delete();
      end else begin
         issue  = !haz && !PCSrcE && RegWriteD && LongLatD && RdD != 0;
         retire = RegWriteW && LongLatW && RdW != 0 && inflight.size() > 0;
         if (issue && retire) begin
            checks++;
            if (RdD == RdW) begin
               errors++;
               $display("FAIL same_reg_issue_retire: reg %0d issued and retired together", RdD);
            end
         end
         if (retire) remove_reg(RdW);
         if (issue)  inflight.push_back(int'(RdD));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cycle();
      rst_n     = ($urandom_range(0, 79) != 0);
      PCSrcE    = ($urandom_range(0, 7) == 0);
      Rs1D      = 5'($urandom_range(0, 7));
      Rs2D      = 5'($urandom_range(0, 7));
      RdD       = 5'($urandom_range(0, 7));
      RegWriteD = 1'($urandom_range(0, 1));
      LongLatD  = ($urandom_range(0, 2) == 0);
      Rs1E      = 5'($urandom_range(0, 3));
      Rs2E      = 5'($urandom_range(0, 3));
      RdM       = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
         RdW       = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
         RegWriteW = 1'b1;
         LongLatW  = 1'b1;
      end else begin
         RdW       = 5'($urandom_range(0, 3));
         RegWriteW = 1'($urandom_range(0, 1));
         LongLatW  = 1'b0;
      end
      cycle();
   endtask

   // Monitor: the DUT presents its full output set every cycle; compare on the falling edge.
   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("StallF",     32'(StallF),     32'(e[43]));
         check("StallD",     32'(StallD),     32'(e[42]));
         check("FlushD",     32'(FlushD),     32'(e[41]));
         check("FlushE",     32'(FlushE),     32'(e[40]));
         check("ForwardAE",  32'(ForwardAE),  32'(e[39:38]));
         check("ForwardBE",  32'(ForwardBE),  32'(e[37:36]));
         check("Busy",       Busy,            e[35:4]);
         check("PendingCnt", 32'(PendingCnt), 32'(e[3:0]));
      end
`ifdef HAZARD_PERF_EN
      if (perf_q.size() > 0) begin : perf_chk
         logic [2*CNT_W-1:0] p;
         p = perf_q.pop_front();
         check("StallCycles", 32'(StallCycles), 32'(p[2*CNT_W-1:CNT_W]));
         check("FlushCycles", 32'(FlushCycles), 32'(p[CNT_W-1:0]));
      end
`endif
   end

   initial begin
`ifdef HAZARD_PERF_EN
      stall_m = '0;
      flush_m = '0;
`endif
      // Reset held two cycles while decode tries to issue a load to x5.
      rst_n = 1'b0;
      idle();
      RegWriteD = 1; LongLatD = 1; RdD = 5;
      @(posedge clk);
      #1;
      cycle();
      cycle();

      // Load-use on x5, stall until the cycle after writeback.
      rst_n = 1'b1;
      idle(); RegWriteD = 1; LongLatD = 1; RdD = 5; cycle();
      idle(); Rs1D = 5; cycle(); cycle();
      RegWriteW = 1; LongLatW = 1; RdW = 5; cycle();
      idle(); Rs1D = 5; cycle();

      // WAW on x7, then a write to x0 must not stall or mark x0.
      idle(); RegWriteD = 1; LongLatD = 1; RdD = 7; cycle();
      idle(); RegWriteD = 1; RdD = 7; Rs1D = 1; Rs2D = 2; cycle();
      RdD = 0; LongLatD = 1; cycle();

      // Capacity: fill x1..x4, fifth long op waits for a retire.
      idle(); RegWriteW = 1; LongLatW = 1; RdW = 7; cycle();
      for (int r = 1; r <= 4; r++) begin
         idle(); RegWriteD = 1; LongLatD = 1; RdD = 5'(r); cycle();
      end
      idle(); RegWriteD = 1; LongLatD = 1; RdD = 6; cycle();
      RegWriteW = 1; LongLatW = 1; RdW = 1; cycle();
      RegWriteW = 0; LongLatW = 0; RdW = 0; cycle();
      idle(); cycle();

      // Redirect while stalled on x5: flush wins, nothing new is marked.
      idle(); RegWriteW = 1; LongLatW = 1; RdW = 2; cycle();
      idle(); RegWriteD = 1; LongLatD = 1; RdD = 5; cycle();
      idle(); Rs1D = 5; PCSrcE = 1; RegWriteD = 1; LongLatD = 1; RdD = 9; cycle();
      idle(); cycle();

      // Forwarding priority M over W, then x0 source.
      idle(); Rs1E = 3; Rs2E = 3; RdM = 3; RegWriteM = 1; RdW = 3; RegWriteW = 1; cycle();
      RegWriteM = 0; cycle();
      Rs1E = 0; cycle();

      // Reset with entries outstanding clears everything.
      idle(); rst_n = 1'b0; cycle();
      rst_n = 1'b1; cycle();

      for (int n = 0; n < 600; n++) rand_cycle();
      idle(); rst_n = 1'b1; cycle();

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Hazard controller that sequences the decode stage of the 5-stage pipeline. It keeps a per-register scoreboard of in-flight long-latency writes (loads, multi-cycle ops) and stalls F/D on RAW/WAW hazards against them. It generates D/E flushes on control-flow redirect and E-stage operand forwarding selects. It sits beside decode and reads decode's Rs1D/Rs2D/RdD and the W-stage write port.

Parameters:
MAX_PENDING, 4, maximum outstanding long-latency ops (1..15)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
Rs1D  in  5  decode source 1
Rs2D  in  5  decode source 2
RdD  in  5  decode destination
RegWriteD  in  1  decode instr writes Rd
LongLatD  in  1  decode instr is long-latency (load/multi-cycle)
Rs1E  in  5  execute source 1
Rs2E  in  5  execute source 2
RdM  in  5  memory-stage destination
RegWriteM  in  1  memory-stage writes
RdW  in  5  writeback destination
RegWriteW  in  1  writeback writes
LongLatW  in  1  writeback instr is long-latency
PCSrcE  in  1  taken branch/jump in E
StallF  out  1  hold PC
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  insert bubble in D/E register
ForwardAE  out  2  00 regfile, 10 from M, 01 from W
ForwardBE  out  2  as ForwardAE
Busy  out  32  scoreboard vector, bit 0 always 0
PendingCnt  out  4  outstanding long-latency ops

Behaviour:
- Reset: all sampled on posedge clk while rst_n=0. Busy=0, PendingCnt=0. While rst_n=0: StallF=StallD=0, FlushD=FlushE=1, ForwardAE/BE=00. Reset mid-operation discards all pending entries; nothing survives.
- Hazard (combinational): haz = (Busy[Rs1D] | Busy[Rs2D] | (RegWriteD & Busy[RdD])) | (LongLatD & PendingCnt==MAX_PENDING). x0 never busy.
- Busy bits read from registered state only. A bit cleared by writeback this cycle still stalls this cycle; decode proceeds the next cycle and reads the regfile.
- Redirect priority: PCSrcE=1 gives FlushD=1, FlushE=1, StallF=StallD=0, regardless of haz. Redirect wins over stall.
- Otherwise, if haz: StallF=StallD=1, FlushE=1, FlushD=0.
- Otherwise: all four controls 0.
- Issue: issue = rst_n & ~haz & ~PCSrcE & RegWriteD & LongLatD & RdD!=0.
- On issue, Busy[RdD] <= 1 at the clock edge.
- Retire: retire = RegWriteW & LongLatW & RdW!=0. On retire, Busy[RdW] <= 0.
- Same register issued and retired in one cycle: set wins. Cannot occur legally given the WAW stall; the bench flags it.
- PendingCnt: +1 on issue, -1 on retire, unchanged if both.
- Retire with PendingCnt=0 is ignored; count saturates at 0 and an assertion fires. Count never exceeds MAX_PENDING.
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E. Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E. Else 00. M has priority over W. ForwardBE uses Rs2E with the same rules.
- Latency: stall/flush/forward outputs are same-cycle combinational; scoreboard and count update 1 cycle after the event.

Optional Feature:
HAZARD_PERF_EN.
- Defined: adds outputs StallCycles and FlushCycles (CNT_W each), reset to 0.
- StallCycles increments each cycle with StallD=1 (rst_n=1). FlushCycles increments each cycle with PCSrcE=1.
- Both counters wrap at 2^CNT_W - 1 back to 0.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
Package hazard_pkg holds:
- typedef fwd_sel_t (2-bit enum FWD_RF=00, FWD_W=01, FWD_M=10)
- constant REG_ZERO=5'd0
- the PendingCnt width

One sub-module, hazard_forward, holds the combinational forwarding mux-select logic and is instantiated twice (A and B). The scoreboard and counter live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with LongLatD/RegWriteD=1, RdD=5 -> Busy=0, PendingCnt=0, FlushD=FlushE=1 throughout.
- Load-use: issue load RdD=5. Next cycle Rs1D=5 -> StallF=StallD=FlushE=1 until the cycle after RegWriteW&LongLatW&RdW=5, then stall drops and Busy[5]=0.
- WAW: Busy[7]=1, RdD=7, RegWriteD=1, unrelated sources -> stall. RdD=0 -> no stall, Busy[0] stays 0.
- Capacity: MAX_PENDING=4, issue 4 loads to x1..x4, 5th long op to x6 -> stall. Retire x1 -> issue proceeds next cycle, PendingCnt returns to 4.
- Redirect during stall: Busy[5]=1, Rs1D=5, PCSrcE=1 -> FlushD=FlushE=1, StallD=0, Busy unchanged, no new bit set.
- Forwarding: Rs1E=Rs2E=3, RdM=3, RegWriteM=1, RdW=3, RegWriteW=1 -> ForwardAE=ForwardBE=10. Then RegWriteM=0 -> 01. Rs1E=0 -> 00.
